// File: rtl/osd_spi_pkg.sv
// Shared definitions for the OSD SPI transmitter: FSM state encoding and OSD command bytes.
package osd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } osd_spi_state_e;

    localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
    localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
    localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;

    // Write command for one of the eight overlay lines.
    function automatic logic [7:0] osd_cmd_write_line(input logic [2:0] line);
        return OSD_CMD_WRITE | {5'b00000, line};
    endfunction

endpackage

// File: rtl/spi_phase_cnt.sv
// Loadable down-counter timing one FSM phase; tc is high while the count sits at zero.
module spi_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/osd_spi_tx.sv
// OSD SPI mode-0 transmitter, MSB first, one SS3-low window per packet.
// Optional byte counter output tx_count enabled by defining OSD_SPI_TX_CNT_EN.
module osd_spi_tx
    import osd_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SS_GUARD = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DI
`ifdef OSD_SPI_TX_CNT_EN
    ,
    output logic [15:0] tx_count
`endif
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SETUP = ST_SETUP;
    localparam logic [2:0] S_LOW   = ST_LOW;
    localparam logic [2:0] S_HIGH  = ST_HIGH;
    localparam logic [2:0] S_NEXT  = ST_NEXT;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_GAP   = ST_GAP;

    localparam int CNT_MAX = (CLK_DIV > SS_GUARD) ? CLK_DIV : SS_GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(SS_GUARD - 1);

    logic [2:0]       state;
    logic [2:0]       nstate;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic [2:0]       idx;
    logic             last_q;
    logic             accept;
    logic             shift;
    logic             di_n;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;

    assign in_ready = reset_n && ((state == S_IDLE) || (state == S_NEXT));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign shift    = (state == S_HIGH) && cnt_tc && (idx != 3'd0);

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (accept) nstate = S_SETUP;
            S_SETUP: if (cnt_tc) nstate = S_LOW;
            S_LOW:   if (cnt_tc) nstate = S_HIGH;
            S_HIGH: begin
                if (cnt_tc) begin
                    if (idx != 3'd0) nstate = S_LOW;
                    else if (last_q) nstate = S_HOLD;
                    else             nstate = S_NEXT;
                end
            end
            S_NEXT:  if (accept) nstate = S_LOW;
            S_HOLD:  if (cnt_tc) nstate = S_GAP;
            S_GAP:   if (cnt_tc) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Every phase change reloads the shared counter with the new phase length.
    assign cnt_load = (nstate != state);
    assign cnt_val  = ((nstate == S_LOW) || (nstate == S_HIGH)) ? DIV_LOAD : GUARD_LOAD;

    spi_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_comb begin
        shreg_n = shreg;
        if (accept)     shreg_n = in_data;
        else if (shift) shreg_n = {shreg[6:0], 1'b0};
    end

    // DI only moves on entry to a phase where SCK is low (or into HIGH from LOW, same bit).
    always_comb begin
        di_n = SPI_DI;
        case (nstate)
            S_IDLE:                 di_n = 1'b0;
            S_SETUP, S_LOW, S_HIGH: di_n = shreg_n[7];
            default:                di_n = SPI_DI;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        shreg <= shreg_n;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx     <= 3'd0;
            last_q  <= 1'b0;
            SPI_SCK <= 1'b0;
            SPI_SS3 <= 1'b1;
            SPI_DI  <= 1'b0;
        end else begin
            state <= nstate;
            if (accept) begin
                idx    <= 3'd7;
                last_q <= in_last;
            end else if (shift) begin
                idx <= idx - 3'd1;
            end
            SPI_SCK <= (nstate == S_HIGH);
            SPI_SS3 <= (nstate == S_IDLE) || (nstate == S_GAP);
            SPI_DI  <= di_n;
        end
    end

`ifdef OSD_SPI_TX_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tx_count <= 16'd0;
        end else if (accept) begin
            tx_count <= (state == S_IDLE) ? 16'd1 : sat_inc16(tx_count);
        end
    end
`endif

endmodule

// File: tb/tb_osd_spi_tx.sv
// Directed bench for osd_spi_tx: single-byte table, stall, back-to-back, reset abort, fast timing.
`timescale 1ns/1ps
module tb_osd_spi_tx;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset_n  = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_last  = 1'b0;
    logic       in_ready, busy, sck, ss3, di;

    logic       f_valid = 1'b0;
    logic [7:0] f_data  = 8'h00;
    logic       f_last  = 1'b0;
    logic       f_ready, f_busy, f_sck, f_ss3, f_di;
`ifdef OSD_SPI_TX_CNT_EN
    logic [15:0] tx_count, f_tx_count;
`endif

    osd_spi_tx dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .busy     (busy),
        .SPI_SCK  (sck),
        .SPI_SS3  (ss3),
        .SPI_DI   (di)
`ifdef OSD_SPI_TX_CNT_EN
        ,
        .tx_count (tx_count)
`endif
    );

    osd_spi_tx #(.CLK_DIV(1), .SS_GUARD(1)) dut_fast (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .in_valid (f_valid),
        .in_data  (f_data),
        .in_last  (f_last),
        .in_ready (f_ready),
        .busy     (f_busy),
        .SPI_SCK  (f_sck),
        .SPI_SS3  (f_ss3),
        .SPI_DI   (f_di)
`ifdef OSD_SPI_TX_CNT_EN
        ,
        .tx_count (f_tx_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Receiver model for the default-timing DUT, sampled on the falling clock edge.
    logic       p_sck = 1'b0;
    logic       p_ss3 = 1'b1;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_bytes [64];
    int         gaps [64];
    int low_cnt = 0, rise_cnt = 0, rx_bits = 0, byte_in_win = 0, sck_low_run = 0;
    int win_len = 0, win_rises = 0, win_n = 0, rx_n = 0, gap_n = 0, rise_total = 0;

    always @(negedge clk_sys) begin
        if (sck && !p_sck) rise_total++;
        if (!ss3) begin
            low_cnt++;
            if (sck && !p_sck) begin
                rx_sh = {rx_sh[6:0], di};
                rise_cnt++;
                if (rx_bits == 0 && byte_in_win > 0 && gap_n < 64) begin
                    gaps[gap_n] = sck_low_run;
                    gap_n++;
                end
                rx_bits++;
                if (rx_bits == 8) begin
                    if (rx_n < 64) rx_bytes[rx_n] = rx_sh;
                    rx_n++;
                    rx_bits = 0;
                    byte_in_win++;
                end
                sck_low_run = 0;
            end else if (!sck) begin
                sck_low_run++;
            end
        end else if (!p_ss3) begin
            win_len   = low_cnt;
            win_rises = rise_cnt;
            win_n++;
        end
        if (ss3) begin
            low_cnt = 0; rise_cnt = 0; rx_bits = 0; byte_in_win = 0; sck_low_run = 0;
        end
        p_sck = sck;
        p_ss3 = ss3;
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk_sys);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("accept_in_time", (n < 2000), 1);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0; in_data = ~d; in_last = ~l;
    endtask

    task automatic wait_ss3_high();
        int n = 0;
        while (!ss3 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("ss3_rise_in_time", (n < 5000), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        int         exp_len;
        int         exp_rises;
        int         exp_first_rise;
        int         exp_ready_gap;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, wbase, gbase, r0;
        logic [7:0] fsh;
        int flow, ftog, frise;
        logic fp;

        vecs[0] = '{8'hA5, 8'hA5, 68, 8, 6, 2};
        vecs[1] = '{8'h00, 8'h00, 68, 8, 6, 2};
        vecs[2] = '{8'hFF, 8'hFF, 68, 8, 6, 2};
        vecs[3] = '{8'h81, 8'h81, 68, 8, 6, 2};
        vecs[4] = '{8'h5A, 8'h5A, 68, 8, 6, 2};
        vecs[5] = '{8'h20, 8'h20, 68, 8, 6, 2};

        // Reset defaults
        repeat (4) begin
            @(negedge clk_sys);
            chk("rst_ss3", ss3, 1);
            chk("rst_sck", sck, 0);
            chk("rst_di", di, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
`ifdef OSD_SPI_TX_CNT_EN
        chk("rst_tx_count", tx_count, 0);
`endif

        // Single-byte packets from the table
        for (int i = 0; i < 6; i++) begin
            base = rx_n;
            send(vecs[i].data, 1'b1);
            chk("ss3_fall_t1", ss3, 0);
            chk("busy_after_accept", busy, 1);
            @(negedge clk_sys);
            k = 0;
            while (!sck && k < 100) begin
                @(negedge clk_sys);
                k++;
            end
            chk("first_rise_delay", k, vecs[i].exp_first_rise);
            wait_ss3_high();
            chk("gap_ready_low", in_ready, 0);
            k = 0;
            while (!in_ready && k < 100) begin
                @(negedge clk_sys);
                k++;
            end
            chk("ready_after_ss3", k, vecs[i].exp_ready_gap);
            chk("single_count", rx_n - base, 1);
            chk("single_byte", rx_bytes[base], vecs[i].exp_byte);
            chk("single_window", win_len, vecs[i].exp_len);
            chk("single_rises", win_rises, vecs[i].exp_rises);
        end

        // Packet with stall between bytes
        base = rx_n; wbase = win_n;
        send(8'h20, 1'b0);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!in_ready && k < 200);
        chk("stall_reach_next", (k < 200), 1);
        repeat (10) begin
            chk("stall_sck_low", sck, 0);
            chk("stall_ss3_low", ss3, 0);
            @(negedge clk_sys);
        end
        send(8'hFF, 1'b1);
        wait_ss3_high();
        repeat (3) @(negedge clk_sys);
        chk("stall_one_window", win_n - wbase, 1);
        chk("stall_count", rx_n - base, 2);
        chk("stall_byte0", rx_bytes[base], 8'h20);
        chk("stall_byte1", rx_bytes[base + 1], 8'hFF);
        chk("stall_rises", win_rises, 16);

        // Back-to-back packet
        base = rx_n; wbase = win_n; gbase = gap_n;
        send(8'h41, 1'b0);
        for (int j = 0; j < 8; j++) send(8'h55, (j == 7));
        wait_ss3_high();
        repeat (3) @(negedge clk_sys);
        chk("b2b_one_window", win_n - wbase, 1);
        chk("b2b_count", rx_n - base, 9);
        chk("b2b_byte0", rx_bytes[base], 8'h41);
        for (int j = 1; j < 9; j++) chk("b2b_byte", rx_bytes[base + j], 8'h55);
        chk("b2b_gap_count", gap_n - gbase, 8);
        for (int j = 0; j < 8; j++) chk("b2b_gap_len", gaps[gbase + j], 5);
`ifdef OSD_SPI_TX_CNT_EN
        chk("b2b_tx_count", tx_count, 9);
`endif

        // Mid-transfer reset during bit 3
        send(8'hA5, 1'b1);
        k = 0;
        while (rise_cnt < 5 && k < 200) begin
            @(negedge clk_sys);
            k++;
        end
        chk("abort_reach_bit3", (k < 200), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ss3", ss3, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        r0 = rise_total;
        repeat (20) @(negedge clk_sys);
        chk("abort_no_edges", rise_total, r0);
        chk("abort_ss3_idle", ss3, 1);
        chk("abort_idle_busy", busy, 0);

        // CLK_DIV=1, SS_GUARD=1 instance
        @(negedge clk_sys);
        f_valid = 1'b1; f_data = 8'h81; f_last = 1'b1;
        chk("fast_ready", f_ready, 1);
        @(posedge clk_sys);
        #1;
        f_valid = 1'b0; f_data = 8'h00; f_last = 1'b0;
        flow = 0; ftog = 0; frise = 0; fsh = 8'h00; fp = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_sys);
            if (f_ss3 && flow > 0) break;
            if (!f_ss3) begin
                flow++;
                if (f_sck != fp) ftog++;
                if (f_sck && !fp) begin
                    fsh = {fsh[6:0], f_di};
                    frise++;
                end
            end
            fp = f_sck;
        end
        chk("fast_window", flow, 18);
        chk("fast_toggles", ftog, 16);
        chk("fast_rises", frise, 8);
        chk("fast_byte", fsh, 8'h81);
`ifdef OSD_SPI_TX_CNT_EN
        chk("fast_tx_count", f_tx_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
